// File: rtl/uart_tx_fifo_if.sv
// Producer/uart-side signal bundle for uart_tx_fifo.
// drop_count exists only when UART_TX_FIFO_DROPCNT_EN is defined.
interface uart_tx_fifo_if #(
    parameter int DEPTH_LOG2 = 4,
    parameter int DATA_WIDTH = 8
);
    logic                  wr;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  full;
    logic                  empty;
    logic [DEPTH_LOG2:0]   count;
    logic                  overflow;
    logic                  u_transmit;
    logic [DATA_WIDTH-1:0] u_tx_byte;
    logic                  u_is_transmitting;
`ifdef UART_TX_FIFO_DROPCNT_EN
    logic [7:0]            drop_count;
`endif

    modport master (
        output wr, wr_data, u_is_transmitting,
`ifdef UART_TX_FIFO_DROPCNT_EN
        input  drop_count,
`endif
        input  full, empty, count, overflow, u_transmit, u_tx_byte
    );

    modport slave (
        input  wr, wr_data, u_is_transmitting,
`ifdef UART_TX_FIFO_DROPCNT_EN
        output drop_count,
`endif
        output full, empty, count, overflow, u_transmit, u_tx_byte
    );
endinterface

// File: rtl/uart_tx_fifo.sv
// Byte queue feeding a uart transmitter through its transmit/is_transmitting handshake.
// Optional saturating dropped-push counter enabled by UART_TX_FIFO_DROPCNT_EN.
module uart_tx_fifo #(
    parameter int DEPTH_LOG2   = 4,
    parameter int DATA_WIDTH   = 8,
    parameter int BUSY_TIMEOUT = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    uart_tx_fifo_if.slave io_bus
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] C_DEPTH = (DEPTH_LOG2 + 1)'(DEPTH);
    localparam int TW = (BUSY_TIMEOUT > 2) ? $clog2(BUSY_TIMEOUT) : 1;
    localparam logic [TW-1:0] C_TO_LAST = TW'(BUSY_TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_SEND      = 2'd1,
        ST_WAIT_BUSY = 2'd2,
        ST_WAIT_DONE = 2'd3
    } state_t;

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [DEPTH_LOG2-1:0] r_wr_ptr;
    logic [DEPTH_LOG2-1:0] r_rd_ptr;
    logic [DEPTH_LOG2:0]   r_count;
    logic                  r_full;
    logic                  r_empty;
    logic                  r_overflow;
    state_t                r_state;
    logic [TW-1:0]         r_to_cnt;
    logic                  r_transmit;
    logic [DATA_WIDTH-1:0] r_tx_byte;

    logic                  w_push;
    logic                  w_pop;
    logic [DEPTH_LOG2:0]   w_count_nxt;

    // Push/pop qualification and next occupancy; full/empty are the registered flags.
    always_comb begin
        w_push      = io_bus.wr & ~r_full;
        w_pop       = (r_state == ST_IDLE) & ~r_empty & ~io_bus.u_is_transmitting;
        w_count_nxt = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_nxt = r_count + 1'b1;
            2'b01:   w_count_nxt = r_count - 1'b1;
            default: w_count_nxt = r_count;
        endcase
    end

    // Storage write; contents need no reset since occupancy gates every read.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= io_bus.wr_data;
        end
    end

    // Write pointer, occupancy, flags and sticky overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr   <= '0;
            r_count    <= '0;
            r_full     <= 1'b0;
            r_empty    <= 1'b1;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (io_bus.wr && r_full) begin
                r_overflow <= 1'b1;
            end
            r_count <= w_count_nxt;
            r_full  <= (w_count_nxt == C_DEPTH);
            r_empty <= (w_count_nxt == '0);
        end
    end

    // Drain FSM: pop, pulse transmit, then wait for the uart to go busy and idle again.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_rd_ptr   <= '0;
            r_to_cnt   <= '0;
            r_transmit <= 1'b0;
            r_tx_byte  <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_pop) begin
                        r_tx_byte  <= r_mem[r_rd_ptr];
                        r_rd_ptr   <= r_rd_ptr + 1'b1;
                        r_transmit <= 1'b1;
                        r_state    <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    r_transmit <= 1'b0;
                    r_to_cnt   <= '0;
                    r_state    <= ST_WAIT_BUSY;
                end
                ST_WAIT_BUSY: begin
                    // A uart that never goes busy lost the pulse; give up rather than retry.
                    if (io_bus.u_is_transmitting) begin
                        r_state <= ST_WAIT_DONE;
                    end else if (r_to_cnt == C_TO_LAST) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_to_cnt <= r_to_cnt + 1'b1;
                    end
                end
                ST_WAIT_DONE: begin
                    if (!io_bus.u_is_transmitting) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_transmit <= 1'b0;
                    r_state    <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef UART_TX_FIFO_DROPCNT_EN
    logic [7:0] r_drop_cnt;

    // Saturating count of pushes rejected because the queue was full.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_drop_cnt <= 8'd0;
        end else if (io_bus.wr && r_full && (r_drop_cnt != 8'hFF)) begin
            r_drop_cnt <= r_drop_cnt + 8'd1;
        end
    end

    assign io_bus.drop_count = r_drop_cnt;
`endif

    assign io_bus.full       = r_full;
    assign io_bus.empty      = r_empty;
    assign io_bus.count      = r_count;
    assign io_bus.overflow   = r_overflow;
    assign io_bus.u_transmit = r_transmit;
    assign io_bus.u_tx_byte  = r_tx_byte;
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo with a small uart model (busy for 10 cycles per byte).
module tb_uart_tx_fifo;
    localparam int BUSY_LEN = 10;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    uart_tx_fifo_if bus ();

    uart_tx_fifo dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .io_bus (bus)
    );

    int checks = 0;
    int errors = 0;

    logic       uart_hold = 1'b0;
    logic       uart_deaf = 1'b0;
    logic       u_busy = 1'b0;
    int         busy_cnt = 0;
    int         viol = 0;
    logic [7:0] tx_q [$];

    assign bus.u_is_transmitting = u_busy;

    // Uart model: capture each pulse, flag pulses while busy, then stay busy BUSY_LEN cycles.
    always @(posedge clk) begin
        if (bus.u_transmit) begin
            tx_q.push_back(bus.u_tx_byte);
            if (u_busy) viol <= viol + 1;
        end
        if (uart_hold) begin
            u_busy   <= 1'b1;
            busy_cnt <= 0;
        end else if (bus.u_transmit && !uart_deaf) begin
            u_busy   <= 1'b1;
            busy_cnt <= BUSY_LEN;
        end else if (busy_cnt > 1) begin
            busy_cnt <= busy_cnt - 1;
        end else begin
            busy_cnt <= 0;
            u_busy   <= 1'b0;
        end
    end

    task automatic push_byte(input logic [7:0] d);
        bus.wr      = 1'b1;
        bus.wr_data = d;
        @(negedge clk);
        bus.wr      = 1'b0;
    endtask

    task automatic test_reset();
        rst_n  = 1'b0;
        bus.wr = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL reset_empty got %b exp 1", bus.empty); end
        checks++; if (bus.full !== 1'b0) begin errors++; $display("FAIL reset_full got %b exp 0", bus.full); end
        checks++; if (bus.count !== 5'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", bus.count); end
        checks++; if (bus.overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got %b exp 0", bus.overflow); end
        checks++; if (bus.u_transmit !== 1'b0) begin errors++; $display("FAIL reset_transmit got %b exp 0", bus.u_transmit); end
        checks++; if (bus.u_tx_byte !== 8'h00) begin errors++; $display("FAIL reset_tx_byte got %h exp 00", bus.u_tx_byte); end
`ifdef UART_TX_FIFO_DROPCNT_EN
        checks++; if (bus.drop_count !== 8'd0) begin errors++; $display("FAIL reset_drop_count got %0d exp 0", bus.drop_count); end
`endif
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_latency();
        tx_q.delete();
        bus.wr      = 1'b1;
        bus.wr_data = 8'h41;
        @(negedge clk);
        bus.wr = 1'b0;
        checks++; if (bus.u_transmit !== 1'b0) begin errors++; $display("FAIL lat_c1_transmit got %b exp 0", bus.u_transmit); end
        checks++; if (bus.count !== 5'd1) begin errors++; $display("FAIL lat_c1_count got %0d exp 1", bus.count); end
        @(negedge clk);
        checks++; if (bus.u_transmit !== 1'b1) begin errors++; $display("FAIL lat_c2_transmit got %b exp 1", bus.u_transmit); end
        checks++; if (bus.u_tx_byte !== 8'h41) begin errors++; $display("FAIL lat_c2_byte got %h exp 41", bus.u_tx_byte); end
        checks++; if (bus.count !== 5'd0) begin errors++; $display("FAIL lat_c2_count got %0d exp 0", bus.count); end
        @(negedge clk);
        checks++; if (bus.u_transmit !== 1'b0) begin errors++; $display("FAIL lat_c3_transmit got %b exp 0", bus.u_transmit); end
        repeat (5) @(negedge clk);
        checks++; if (bus.u_tx_byte !== 8'h41) begin errors++; $display("FAIL lat_hold_byte got %h exp 41", bus.u_tx_byte); end
        repeat (10) @(negedge clk);
        checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL lat_end_empty got %b exp 1", bus.empty); end
        checks++; if (bus.count !== 5'd0) begin errors++; $display("FAIL lat_end_count got %0d exp 0", bus.count); end
        checks++; if (tx_q.size() !== 1) begin errors++; $display("FAIL lat_pulses got %0d exp 1", tx_q.size()); end
    endtask

    task automatic test_burst();
        int  peak;
        bit  ok;
        tx_q.delete();
        peak = 0;
        for (int i = 1; i <= 5; i++) begin
            push_byte(8'(i));
            if (int'(bus.count) > peak) peak = int'(bus.count);
        end
        for (int i = 0; i < 200 && tx_q.size() < 5; i++) begin
            @(negedge clk);
            if (int'(bus.count) > peak) peak = int'(bus.count);
        end
        repeat (14) @(negedge clk);
        checks++; if (peak !== 4) begin errors++; $display("FAIL burst_peak got %0d exp 4", peak); end
        ok = (tx_q.size() == 5);
        for (int i = 0; i < 5 && ok; i++) if (tx_q[i] !== 8'(i + 1)) ok = 1'b0;
        checks++; if (!ok) begin errors++; $display("FAIL burst_order got %0d bytes exp 5 in order 01..05", tx_q.size()); end
        checks++; if (viol !== 0) begin errors++; $display("FAIL burst_pulse_while_busy got %0d exp 0", viol); end
        checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL burst_empty got %b exp 1", bus.empty); end
    endtask

    task automatic test_overflow();
        bit ok;
        uart_hold = 1'b1;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 16; i++) push_byte(8'h80 + 8'(i));
        checks++; if (bus.full !== 1'b1) begin errors++; $display("FAIL ovf_full got %b exp 1", bus.full); end
        checks++; if (bus.count !== 5'd16) begin errors++; $display("FAIL ovf_count16 got %0d exp 16", bus.count); end
        checks++; if (bus.overflow !== 1'b0) begin errors++; $display("FAIL ovf_early got %b exp 0", bus.overflow); end
        push_byte(8'h90);
        checks++; if (bus.overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky_set got %b exp 1", bus.overflow); end
        checks++; if (bus.count !== 5'd16) begin errors++; $display("FAIL ovf_count_after_drop got %0d exp 16", bus.count); end
`ifdef UART_TX_FIFO_DROPCNT_EN
        checks++; if (bus.drop_count !== 8'd1) begin errors++; $display("FAIL ovf_drop_count got %0d exp 1", bus.drop_count); end
`endif
        tx_q.delete();
        uart_hold = 1'b0;
        for (int i = 0; i < 600 && tx_q.size() < 16; i++) @(negedge clk);
        repeat (14) @(negedge clk);
        ok = (tx_q.size() == 16);
        for (int i = 0; i < 16 && ok; i++) if (tx_q[i] !== 8'h80 + 8'(i)) ok = 1'b0;
        checks++; if (!ok) begin errors++; $display("FAIL ovf_order got %0d bytes exp 16 in order 80..8F", tx_q.size()); end
        checks++; if (bus.overflow !== 1'b1) begin errors++; $display("FAIL ovf_stays got %b exp 1", bus.overflow); end
        checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL ovf_drained got %b exp 1", bus.empty); end
        checks++; if (viol !== 0) begin errors++; $display("FAIL ovf_pulse_while_busy got %0d exp 0", viol); end
    endtask

    task automatic test_wrap();
        bit ok;
        tx_q.delete();
        for (int b = 0; b < 2; b++) begin
            for (int i = 0; i < 10; i++) push_byte(8'h10 + 8'(b * 10 + i));
            for (int i = 0; i < 400 && tx_q.size() < (b + 1) * 10; i++) @(negedge clk);
            repeat (14) @(negedge clk);
        end
        ok = (tx_q.size() == 20);
        for (int i = 0; i < 20 && ok; i++) if (tx_q[i] !== 8'h10 + 8'(i)) ok = 1'b0;
        checks++; if (!ok) begin errors++; $display("FAIL wrap_order got %0d bytes exp 20 in order 10..23", tx_q.size()); end
        checks++; if (bus.count !== 5'd0) begin errors++; $display("FAIL wrap_count got %0d exp 0", bus.count); end
    endtask

    task automatic test_timeout();
        int n;
        int t0;
        int t1;
        tx_q.delete();
        uart_deaf = 1'b1;
        n = 0; t0 = -1; t1 = -1;
        push_byte(8'hA1);
        push_byte(8'hA2);
        for (int i = 0; i < 60; i++) begin
            if (bus.u_transmit) begin
                if (n == 0) t0 = i;
                if (n == 1) t1 = i;
                n++;
            end
            @(negedge clk);
        end
        uart_deaf = 1'b0;
        checks++; if (n !== 2) begin errors++; $display("FAIL tmo_pulses got %0d exp 2", n); end
        checks++; if (t1 - t0 !== 6) begin errors++; $display("FAIL tmo_gap got %0d exp 6", t1 - t0); end
        checks++; if (tx_q.size() !== 2 || tx_q[1] !== 8'hA2) begin errors++; $display("FAIL tmo_order got %0d bytes exp 2 ending A2", tx_q.size()); end
        checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL tmo_empty got %b exp 1", bus.empty); end
    endtask

    task automatic test_reset_mid();
        tx_q.delete();
        for (int i = 0; i < 4; i++) push_byte(8'h61 + 8'(i));
        @(negedge clk);
        checks++; if (bus.count !== 5'd3) begin errors++; $display("FAIL rmid_pre_count got %0d exp 3", bus.count); end
        rst_n = 1'b0;
        #1;
        checks++; if (bus.count !== 5'd0) begin errors++; $display("FAIL rmid_count got %0d exp 0", bus.count); end
        checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL rmid_empty got %b exp 1", bus.empty); end
        checks++; if (bus.u_tx_byte !== 8'h00) begin errors++; $display("FAIL rmid_tx_byte got %h exp 00", bus.u_tx_byte); end
        checks++; if (bus.overflow !== 1'b0) begin errors++; $display("FAIL rmid_overflow got %b exp 0", bus.overflow); end
`ifdef UART_TX_FIFO_DROPCNT_EN
        checks++; if (bus.drop_count !== 8'd0) begin errors++; $display("FAIL rmid_drop_count got %0d exp 0", bus.drop_count); end
`endif
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        tx_q.delete();
        repeat (30) @(negedge clk);
        checks++; if (tx_q.size() !== 0) begin errors++; $display("FAIL rmid_no_tx got %0d pulses exp 0", tx_q.size()); end
        push_byte(8'h5A);
        repeat (20) @(negedge clk);
        checks++; if (tx_q.size() !== 1 || tx_q[0] !== 8'h5A) begin errors++; $display("FAIL rmid_new_push got %0d pulses exp 1 of 5A", tx_q.size()); end
    endtask

    initial begin
        bus.wr      = 1'b0;
        bus.wr_data = 8'h00;
        test_reset();
        test_latency();
        test_burst();
        test_overflow();
        test_wrap();
        test_timeout();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout exp completion");
        $fatal(1);
    end
endmodule
